// File: rtl/emmc_ddr_rx_block_if.sv
// eMMC DDR receive block bus: DAT sample pairs and control in, byte stream and status out.
// master drives samples/Start/Abort; slave is the receive engine.
interface emmc_ddr_rx_block_if;
  logic [3:0] RxPos;
  logic [3:0] RxNeg;
  logic       Start;
  logic       Abort;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       Busy;
  logic       Done;
  logic       CrcError;
  logic       EndBitError;
  logic       Timeout;

  modport master (
    output RxPos, RxNeg, Start, Abort,
    input  DataOut, DataValid, Busy, Done,
    input  CrcError, EndBitError, Timeout
  );

  modport slave (
    input  RxPos, RxNeg, Start, Abort,
    output DataOut, DataValid, Busy, Done,
    output CrcError, EndBitError, Timeout
  );
endinterface

// File: rtl/emmc_ddr_rx_block.sv
// 4-bit DDR eMMC receive engine: start bit, byte assembly, 8x CRC16, end bit.
// Ports: Clk, Reset_n (async low), bus (slave modport of emmc_ddr_rx_block_if).
module emmc_ddr_rx_block #(
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  Clk,
  input logic                  Reset_n,
  emmc_ddr_rx_block_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CRC  = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [11:0] LAST_BYTE = 12'(BLOCK_BYTES - 1);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] POLY      = 16'h1021;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [11:0] cnt;
  logic [15:0] to_cnt;
  logic [15:0] crc_p [4];
  logic [15:0] crc_n [4];
  logic        mism;
  logic [7:0]  data_q;
  logic        dv_q;
  logic        crc_err_q;
  logic        end_err_q;
  logic        to_q;
  logic        start_bit;
  logic        end_ok;
  logic        to_hit;
  logic [3:0]  crc_idx;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  assign start_bit = (bus.RxPos == 4'h0) && (bus.RxNeg == 4'h0);
  assign end_ok    = (bus.RxPos == 4'hF) && (bus.RxNeg == 4'hF);
  assign to_hit    = (to_cnt == TO_LIMIT);
  // CRC cycle k carries bit 15-k
  assign crc_idx   = ~cnt[3:0];

  always_comb begin
    state_nx = state;
    if (bus.Abort && state != S_IDLE) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (bus.Start) state_nx = S_WAIT;
        S_WAIT: begin
          if (start_bit)   state_nx = S_DATA;
          else if (to_hit) state_nx = S_DONE;
        end
        S_DATA: if (cnt == LAST_BYTE) state_nx = S_CRC;
        S_CRC:  if (cnt[3:0] == 4'hF) state_nx = S_END;
        S_END:  state_nx = S_DONE;
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      to_cnt    <= '0;
      mism      <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      to_q      <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        crc_p[n] <= '0;
        crc_n[n] <= '0;
      end
    end else begin
      state <= state_nx;
      dv_q  <= (state == S_DATA) && !bus.Abort;
      if (state == S_DATA && !bus.Abort)
        data_q <= {bus.RxPos, bus.RxNeg};

      unique case (state)
        S_IDLE: begin
          if (bus.Start) begin
            cnt       <= '0;
            to_cnt    <= '0;
            mism      <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            to_q      <= 1'b0;
            for (int n = 0; n < 4; n++) begin
              crc_p[n] <= '0;
              crc_n[n] <= '0;
            end
          end
        end
        S_WAIT: begin
          if (!start_bit) begin
            if (!to_hit)
              to_cnt <= to_cnt + 16'd1;
            else if (!bus.Abort)
              to_q <= 1'b1;
          end
        end
        S_DATA: begin
          for (int n = 0; n < 4; n++) begin
            crc_p[n] <= crc_step(crc_p[n], bus.RxPos[n]);
            crc_n[n] <= crc_step(crc_n[n], bus.RxNeg[n]);
          end
          // counter restarts so CRC state can reuse it
          if (cnt == LAST_BYTE) cnt <= '0;
          else                  cnt <= cnt + 12'd1;
        end
        S_CRC: begin
          for (int n = 0; n < 4; n++) begin
            if (bus.RxPos[n] != crc_p[n][crc_idx]) mism <= 1'b1;
            if (bus.RxNeg[n] != crc_n[n][crc_idx]) mism <= 1'b1;
          end
          cnt <= cnt + 12'd1;
        end
        S_END: begin
          if (!bus.Abort) begin
            end_err_q <= !end_ok;
            crc_err_q <= mism;
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.DataOut     = data_q;
  assign bus.DataValid   = dv_q;
  assign bus.Busy        = (state != S_IDLE);
  assign bus.Done        = (state == S_DONE);
  assign bus.CrcError    = crc_err_q;
  assign bus.EndBitError = end_err_q;
  assign bus.Timeout     = to_q;

endmodule

// File: tb/tb_emmc_ddr_rx_block.sv
// Self-checking bench for emmc_ddr_rx_block (BLOCK_BYTES=4, TIMEOUT_CYCLES=10).
// Reference CRCs come from polynomial long division of each line's bit stream.
module tb_emmc_ddr_rx_block;
  localparam int B  = 4;
  localparam int TO = 10;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  emmc_ddr_rx_block_if bus();

  emmc_ddr_rx_block #(
    .BLOCK_BYTES(B),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_bytes [B];
  logic [7:0] got_b [$];
  int         got_c [$];
  int         done_c;
  int         done_n;
  logic       f_crc, f_end, f_to;
  logic       busy_log [64];

  // remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] crc_ref(input int line, input bit neg);
    bit a [B+16];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    for (int i = 0; i < B + 16; i++) a[i] = 1'b0;
    for (int i = 0; i < B; i++)
      a[i] = neg ? tx_bytes[i][line] : tx_bytes[i][4+line];
    for (int i = 0; i < B; i++)
      if (a[i])
        for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ g[16-j];
    for (int j = 0; j < 16; j++) r[15-j] = a[B+j];
    return r;
  endfunction

  task automatic drive_idle();
    bus.RxPos = 4'hF;
    bus.RxNeg = 4'hF;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
  endtask

  // c=0 is the Start cycle; start bit at S=1+w; returns S
  task automatic run_frame(
    input int w, input int len, input int abort_c,
    input logic [3:0] pre_p, input logic [3:0] pre_n,
    input int flip_line, input int flip_bit,
    input logic [3:0] end_p, input logic [3:0] end_n,
    output int s
  );
    logic [15:0] cp [4];
    logic [15:0] cn [4];
    int k;
    s = 1 + w;
    for (int n = 0; n < 4; n++) begin
      cp[n] = crc_ref(n, 1'b0);
      cn[n] = crc_ref(n, 1'b1);
    end
    if (flip_line >= 0) cn[flip_line][flip_bit] = ~cn[flip_line][flip_bit];
    got_b.delete();
    got_c.delete();
    done_c = -1;
    done_n = 0;
    f_crc = 1'bx; f_end = 1'bx; f_to = 1'bx;
    for (int c = 0; c < len; c++) begin
      if (c < 64) busy_log[c] = bus.Busy;
      if (bus.DataValid) begin
        got_b.push_back(bus.DataOut);
        got_c.push_back(c);
      end
      if (bus.Done) begin
        done_n++;
        done_c = c;
        f_crc = bus.CrcError;
        f_end = bus.EndBitError;
        f_to  = bus.Timeout;
      end
      bus.Start = (c == 0);
      bus.Abort = (c == abort_c);
      if (c < s) begin
        bus.RxPos = pre_p;
        bus.RxNeg = pre_n;
      end else if (c == s) begin
        bus.RxPos = 4'h0;
        bus.RxNeg = 4'h0;
      end else if (c <= s + B) begin
        bus.RxPos = tx_bytes[c-s-1][7:4];
        bus.RxNeg = tx_bytes[c-s-1][3:0];
      end else if (c <= s + B + 16) begin
        k = c - s - B - 1;
        for (int n = 0; n < 4; n++) begin
          bus.RxPos[n] = cp[n][15-k];
          bus.RxNeg[n] = cn[n][15-k];
        end
      end else if (c == s + B + 17) begin
        bus.RxPos = end_p;
        bus.RxNeg = end_n;
      end else begin
        bus.RxPos = 4'hF;
        bus.RxNeg = 4'hF;
      end
      @(posedge Clk);
      #1;
    end
    drive_idle();
  endtask

  task automatic check_block(input string tag, input int s,
                             input logic exp_crc, input logic exp_end);
    n_tests++;
    if (got_b.size() !== B) begin
      n_fail++;
      $display("FAIL %s nbytes got %0d want %0d", tag, got_b.size(), B);
    end
    for (int i = 0; i < B && i < got_b.size(); i++) begin
      n_tests++;
      if (got_b[i] !== tx_bytes[i] || got_c[i] !== s + 2 + i) begin
        n_fail++;
        $display("FAIL %s byte%0d got %h@%0d want %h@%0d", tag, i,
                 got_b[i], got_c[i], tx_bytes[i], s + 2 + i);
      end
    end
    n_tests++;
    if (done_n !== 1 || done_c !== s + 18 + B) begin
      n_fail++;
      $display("FAIL %s done got n=%0d@%0d want 1@%0d", tag, done_n,
               done_c, s + 18 + B);
    end
    n_tests++;
    if (f_crc !== exp_crc || f_end !== exp_end || f_to !== 1'b0) begin
      n_fail++;
      $display("FAIL %s flags got crc=%b end=%b to=%b want %b %b 0", tag,
               f_crc, f_end, f_to, exp_crc, exp_end);
    end
    n_tests++;
    if (done_c > 0 && done_c < 63 &&
        (busy_log[done_c] !== 1'b1 || busy_log[done_c+1] !== 1'b0)) begin
      n_fail++;
      $display("FAIL %s busy_fall got %b%b want 10", tag,
               busy_log[done_c], busy_log[done_c+1]);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.DataOut, bus.DataValid, bus.Busy, bus.Done, bus.CrcError,
         bus.EndBitError, bus.Timeout} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset outputs got %h/%b%b%b%b%b%b want 00/000000",
               bus.DataOut, bus.DataValid, bus.Busy, bus.Done,
               bus.CrcError, bus.EndBitError, bus.Timeout);
    end
  endtask

  task automatic test_good_block();
    int s;
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
    tx_bytes[2] = 8'hFF; tx_bytes[3] = 8'h00;
    run_frame(0, B + 24, -1, 4'hF, 4'hF, -1, 0, 4'hF, 4'hF, s);
    check_block("good_fixed", s, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < B; i++) tx_bytes[i] = 8'($urandom);
      run_frame(int'($urandom_range(0, 4)), B + 28, -1, 4'hF, 4'hF,
                -1, 0, 4'hF, 4'hF, s);
      check_block("good_rand", s, 1'b0, 1'b0);
    end
  endtask

  task automatic test_crc_error();
    int s;
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
    tx_bytes[2] = 8'hFF; tx_bytes[3] = 8'h00;
    run_frame(1, B + 25, -1, 4'hF, 4'hF, 2, 7, 4'hF, 4'hF, s);
    check_block("crc_n2b7", s, 1'b1, 1'b0);
    for (int i = 0; i < B; i++) tx_bytes[i] = 8'($urandom);
    run_frame(0, B + 24, -1, 4'hF, 4'hF, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)), 4'hF, 4'hF, s);
    check_block("crc_rand", s, 1'b1, 1'b0);
  endtask

  task automatic test_end_bit();
    int s;
    for (int i = 0; i < B; i++) tx_bytes[i] = 8'($urandom);
    run_frame(2, B + 26, -1, 4'hF, 4'hF, -1, 0, 4'hF, 4'hE, s);
    check_block("endbit", s, 1'b0, 1'b1);
  endtask

  task automatic test_timeout(input string tag,
                              input logic [3:0] pp, input logic [3:0] pn);
    int s;
    run_frame(100, 16, -1, pp, pn, -1, 0, 4'hF, 4'hF, s);
    n_tests++;
    if (done_n !== 1 || done_c !== 2 + TO || f_to !== 1'b1 ||
        got_b.size() !== 0) begin
      n_fail++;
      $display("FAIL %s got done=%0d@%0d to=%b nbytes=%0d want 1@%0d 1 0",
               tag, done_n, done_c, f_to, got_b.size(), 2 + TO);
    end
    n_tests++;
    if (bus.Timeout !== 1'b1 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s sticky got to=%b busy=%b want 1 0", tag,
               bus.Timeout, bus.Busy);
    end
    bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    n_tests++;
    if (bus.Timeout !== 1'b0 || bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s restart got to=%b busy=%b want 0 1", tag,
               bus.Timeout, bus.Busy);
    end
    bus.Abort = 1'b1;
    @(posedge Clk); #1;
    bus.Abort = 1'b0;
    n_tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s abort_wait got busy=%b done=%b want 0 0", tag,
               bus.Busy, bus.Done);
    end
  endtask

  task automatic test_abort();
    int s;
    for (int i = 0; i < B; i++) tx_bytes[i] = 8'($urandom);
    s = 1 + 2;
    run_frame(2, B + 26, s + 3, 4'hF, 4'hF, -1, 0, 4'hF, 4'hF, s);
    n_tests++;
    if (got_b.size() !== 2 || done_n !== 0) begin
      n_fail++;
      $display("FAIL abort got nbytes=%0d done=%0d want 2 0",
               got_b.size(), done_n);
    end
    for (int i = 0; i < 2 && i < got_b.size(); i++) begin
      n_tests++;
      if (got_b[i] !== tx_bytes[i] || got_c[i] !== s + 2 + i) begin
        n_fail++;
        $display("FAIL abort byte%0d got %h@%0d want %h@%0d", i,
                 got_b[i], got_c[i], tx_bytes[i], s + 2 + i);
      end
    end
    n_tests++;
    if (busy_log[s+3] !== 1'b1 || busy_log[s+4] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort busy got %b%b want 10", busy_log[s+3],
               busy_log[s+4]);
    end
    for (int i = 0; i < B; i++) tx_bytes[i] = 8'($urandom);
    run_frame(1, B + 25, -1, 4'hF, 4'hF, -1, 0, 4'hF, 4'hF, s);
    check_block("after_abort", s, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int s;
    int dn;
    for (int i = 0; i < B; i++) tx_bytes[i] = 8'($urandom);
    run_frame(0, 1 + B + 6, -1, 4'hF, 4'hF, -1, 0, 4'hF, 4'hF, s);
    n_tests++;
    if (bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid pre_busy got %b want 1", bus.Busy);
    end
    #2 Reset_n = 1'b0;
    #1;
    test_reset();
    #1 Reset_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk); #1;
      if (bus.Done || bus.Busy || bus.DataValid) dn++;
    end
    n_tests++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL rst_mid after got %0d active cycles want 0", dn);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    test_reset();
    test_good_block();
    test_crc_error();
    test_end_bit();
    test_timeout("timeout", 4'hF, 4'hF);
    test_timeout("partial_start", 4'h0, 4'h8);
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/emmc_ddr_rx_block.md
# emmc_ddr_rx_block

Receive-side data-block engine for the eMMC host controller's 4-bit DDR data path. It consumes the per-cycle rising/falling-edge sample pairs produced by the four DAT-line DDR input cells. It detects the start bit, assembles one byte per clock, checks the eight per-line/per-edge CRC16s and the end bit, and reports completion status to the transfer controller.

## Interface
Parameters:
- BLOCK_BYTES, 512: data bytes per block; legal range 1..4095.
- TIMEOUT_CYCLES, 65535: maximum WAIT_START cycles before timeout; legal range 1..65535.

Ports:
- Clk  in  1  controller clock; the same clock that drives the DAT output cells.
- Reset_n  in  1  asynchronous, active-low reset.
- RxPos  in  4  rising-edge samples of DAT[3:0]; bit n is line n.
- RxNeg  in  4  falling-edge samples of DAT[3:0], aligned to the same Clk cycle as RxPos.
- Start  in  1  one-cycle arm pulse; honoured only in IDLE.
- Abort  in  1  synchronous abort; returns the block to IDLE with no Done.
- DataOut  out  8  received byte: {RxPos[3:0], RxNeg[3:0]}.
- DataValid  out  1  one-cycle qualifier for DataOut; there is no backpressure.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at end of block, success or failure.
- CrcError  out  1  sticky status; cleared on the next accepted Start.
- EndBitError  out  1  sticky status; cleared on the next accepted Start.
- Timeout  out  1  sticky status; cleared on the next accepted Start.

## Operation
- States: IDLE, WAIT_START, DATA, CRC, END, DONE.
- IDLE -> WAIT_START on Start. The same transition clears the status flags, the byte counter, the timeout counter and all eight CRC registers to 0x0000.
- WAIT_START:
  - Start bit = RxPos==4'h0 and RxNeg==4'h0 in the same cycle. On a start bit, go to DATA.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES, set Timeout and go to DONE.
- DATA:
  - Each cycle, register {RxPos,RxNeg} to DataOut and pulse DataValid the following cycle.
  - Feed each RxPos[n] into CRC register P[n] and each RxNeg[n] into N[n].
  - CRC16-CCITT, polynomial x^16+x^12+x^5+1, serial, MSB first.
  - After BLOCK_BYTES cycles, go to CRC.
- CRC:
  - 16 cycles. Cycle k (0..15) carries received CRC bit 15-k: RxPos[n] for P[n], RxNeg[n] for N[n].
  - Compare each bit against the computed register. Any mismatch sets an internal mismatch latch.
  - The computed registers do not advance in this state.
  - After 16 cycles, go to END.
- END: one cycle. The end bit requires RxPos==4'hF and RxNeg==4'hF; anything else sets EndBitError. Transfer the mismatch latch into CrcError. Go to DONE.
- DONE: pulse Done for one cycle, then go to IDLE. Status flags hold until the next accepted Start.
- Start outside IDLE is ignored.
- Abort in any state other than IDLE: go to IDLE next cycle. Busy drops, DataValid is forced low, no Done pulse, status flags are unchanged. Abort has priority over every other transition, including the start bit and the timeout.
- A start bit on only some lines (e.g. RxPos==4'h0, RxNeg==4'h8) is not a start bit; keep waiting.
- Byte counter width is 12 bits. There is no wrap, because the DATA exit occurs at BLOCK_BYTES.

## Timing
- Reset values: DataOut=8'h00; DataValid, Busy, Done, CrcError, EndBitError, Timeout all 0; state=IDLE.
- Busy rises the cycle after Start is sampled.
- Latency:
  - Start-bit cycle = S. Byte i is sampled in cycle S+1+i and presented on DataOut/DataValid in cycle S+2+i.
  - The last DataValid is at S+1+BLOCK_BYTES, which coincides with the first CRC cycle.
- CRC cycles: S+1+BLOCK_BYTES .. S+16+BLOCK_BYTES. END cycle: S+17+BLOCK_BYTES. Done: S+18+BLOCK_BYTES.
- CrcError and EndBitError become visible in the same cycle as Done.
- Timeout: with Start in cycle T and no start bit, Done and Timeout assert in cycle T+2+TIMEOUT_CYCLES.
- Busy falls the cycle after Done. A new Start is accepted that same cycle.
- Reset_n low mid-transfer: all outputs clear asynchronously. No Done is issued.

## Test plan
- BLOCK_BYTES=4, correct CRCs, bytes 0xA5,0x3C,0xFF,0x00 -> DataValid at S+2..S+5 with exactly those bytes; Done at S+22; CrcError=0, EndBitError=0.
- Same block with bit 7 of received N[2] CRC flipped -> all 4 bytes still delivered; Done at S+22 with CrcError=1.
- End bit driven as RxPos=4'hF, RxNeg=4'hE -> EndBitError=1, CrcError=0, Done pulse present.
- TIMEOUT_CYCLES=10, lines held 4'hF -> Timeout=1 and Done at T+12. A subsequent Start clears Timeout in the following cycle.
- Abort asserted at S+3 -> DataValid stops after S+3, Busy low at S+4, no Done. A fresh Start receives a full block correctly.
- Reset_n pulsed low during the CRC state -> all outputs 0 immediately. Partial start pattern (RxPos=0, RxNeg=4'h8) in WAIT_START -> no transition to DATA.
